// File: rtl/t_ff_counter_if.sv
// Control/status bundle for t_ff_counter: count/load controls in, count state and debug view out.
interface t_ff_counter_if #(
    parameter int unsigned WIDTH = 8
);
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] t_vec;
    logic             wrap;

    modport master (
        output en, up_dn, load, load_val,
        input  q, t_vec, wrap
    );

    modport slave (
        input  en, up_dn, load, load_val,
        output q, t_vec, wrap
    );
endinterface

// File: rtl/t_ff_counter.sv
// Modulo-MODULUS up/down counter built from T flip-flops with ripple-carry toggle enables.
// Define T_FF_COUNTER_SATURATE_EN to hold at the limits instead of wrapping (wrap = limit-hit).
module t_ff_counter #(
    parameter int unsigned     WIDTH   = 8,
    parameter longint unsigned MODULUS = 256
) (
    input  logic           clk,
    input  logic           reset,
    t_ff_counter_if.slave  bus
);

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] t_nat;
    logic [WIDTH-1:0] t_vec;
    logic             carry;
    logic             at_limit;

    always_comb begin
        t_nat = '0;
        carry = 1'b1;
        // Bit i toggles when all lower bits are 1 (up) or all 0 (down).
        for (int i = 0; i < WIDTH; i++) begin
            t_nat[i] = carry;
            carry    = carry & (bus.up_dn ? q_q[i] : ~q_q[i]);
        end

        at_limit = bus.up_dn ? (q_q == MaxVal) : (q_q == '0);

        q_d    = q_q;
        wrap_d = 1'b0;
        t_vec  = '0;

        if (bus.load) begin
            q_d = (64'(bus.load_val) >= MODULUS) ? MaxVal : bus.load_val;
        end else if (bus.en) begin
            if (at_limit) begin
                wrap_d = 1'b1;
`ifdef T_FF_COUNTER_SATURATE_EN
                q_d = q_q;
`else
                q_d = bus.up_dn ? '0 : MaxVal;
`endif
            end else begin
                q_d = q_q ^ t_nat;
            end
            // Report exactly the bits that flip, including the modulus override.
            t_vec = q_q ^ q_d;
        end

        if (reset) begin
            t_vec = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.q     = q_q;
    assign bus.t_vec = t_vec;
    assign bus.wrap  = wrap_q;

endmodule

// File: tb/tb_t_ff_counter.sv
// Scoreboard bench for t_ff_counter: four instances (M256/W8, M10/W4, M100/W8, M16/W4).
module tb_t_ff_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    localparam int NDut = 4;

    logic       rst_s  [NDut];
    logic       en_s   [NDut];
    logic       up_s   [NDut];
    logic       ld_s   [NDut];
    logic [7:0] lval_s [NDut];
    logic [7:0] q_s    [NDut];
    logic [7:0] tv_s   [NDut];
    logic       wrap_s [NDut];

    t_ff_counter_if #(.WIDTH(8)) if0 ();
    t_ff_counter_if #(.WIDTH(4)) if1 ();
    t_ff_counter_if #(.WIDTH(8)) if2 ();
    t_ff_counter_if #(.WIDTH(4)) if3 ();

    t_ff_counter #(.WIDTH(8), .MODULUS(256)) u_dut0 (.clk(clk), .reset(rst_s[0]), .bus(if0));
    t_ff_counter #(.WIDTH(4), .MODULUS(10))  u_dut1 (.clk(clk), .reset(rst_s[1]), .bus(if1));
    t_ff_counter #(.WIDTH(8), .MODULUS(100)) u_dut2 (.clk(clk), .reset(rst_s[2]), .bus(if2));
    t_ff_counter #(.WIDTH(4), .MODULUS(16))  u_dut3 (.clk(clk), .reset(rst_s[3]), .bus(if3));

    assign if0.en = en_s[0]; assign if0.up_dn = up_s[0]; assign if0.load = ld_s[0];
    assign if0.load_val = lval_s[0];
    assign if1.en = en_s[1]; assign if1.up_dn = up_s[1]; assign if1.load = ld_s[1];
    assign if1.load_val = lval_s[1][3:0];
    assign if2.en = en_s[2]; assign if2.up_dn = up_s[2]; assign if2.load = ld_s[2];
    assign if2.load_val = lval_s[2];
    assign if3.en = en_s[3]; assign if3.up_dn = up_s[3]; assign if3.load = ld_s[3];
    assign if3.load_val = lval_s[3][3:0];

    assign q_s[0] = if0.q;        assign tv_s[0] = if0.t_vec;        assign wrap_s[0] = if0.wrap;
    assign q_s[1] = 8'(if1.q);    assign tv_s[1] = 8'(if1.t_vec);    assign wrap_s[1] = if1.wrap;
    assign q_s[2] = if2.q;        assign tv_s[2] = if2.t_vec;        assign wrap_s[2] = if2.wrap;
    assign q_s[3] = 8'(if3.q);    assign tv_s[3] = 8'(if3.t_vec);    assign wrap_s[3] = if3.wrap;

    typedef struct {
        int         id;
        string      name;
        logic [7:0] q;
        logic       wrap;
        logic [7:0] tv;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Drive one cycle on DUT id (others idle) and queue what the monitor must see this cycle:
    // eq/ew are the state left by the previous edge, et the toggle view for these inputs.
    task automatic vec(input int id, input string name, input bit rst, input bit en,
                       input bit up, input bit ld, input logic [7:0] lval,
                       input logic [7:0] eq, input bit ew, input logic [7:0] et);
        exp_t r;
        @(posedge clk);
        #1;
        for (int d = 0; d < NDut; d++) begin
            rst_s[d] = 1'b0; en_s[d] = 1'b0; ld_s[d] = 1'b0;
        end
        rst_s[id] = rst; en_s[id] = en; up_s[id] = up; ld_s[id] = ld; lval_s[id] = lval;
        r.id = id; r.name = name; r.q = eq; r.wrap = ew; r.tv = et;
        sb.push_back(r);
    endtask

    // Monitor: every cycle presents an output; compare at the falling edge.
    initial begin
        exp_t r;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                r = sb.pop_front();
                n_cmp += 3;
                if (q_s[r.id] !== r.q) begin
                    n_err++;
                    $display("FAIL %s dut%0d q: got %0d want %0d at %0t",
                             r.name, r.id, q_s[r.id], r.q, $time);
                end
                if (wrap_s[r.id] !== r.wrap) begin
                    n_err++;
                    $display("FAIL %s dut%0d wrap: got %0b want %0b at %0t",
                             r.name, r.id, wrap_s[r.id], r.wrap, $time);
                end
                if (tv_s[r.id] !== r.tv) begin
                    n_err++;
                    $display("FAIL %s dut%0d t_vec: got %h want %h at %0t",
                             r.name, r.id, tv_s[r.id], r.tv, $time);
                end
            end
        end
    end

    initial begin
        int v, nv;
        for (int d = 0; d < NDut; d++) begin
            rst_s[d] = 1'b1; en_s[d] = 1'b0; up_s[d] = 1'b1; ld_s[d] = 1'b0; lval_s[d] = '0;
        end
        @(posedge clk);
        #1;
        // Reset state, with en and load pending: reset must win and gate t_vec.
        for (int d = 0; d < NDut; d++) vec(d, "reset", 1, 1, 1, 1, 8'd7, 8'd0, 0, 8'd0);

`ifndef T_FF_COUNTER_SATURATE_EN
        // Up count M256 for 300 cycles.
        for (int i = 0; i < 300; i++) begin
            v = i % 256; nv = (i + 1) % 256;
            vec(0, "up256", 0, 1, 1, 0, 8'd0, 8'(v), (v == 0 && i > 0), 8'(v ^ nv));
        end
        // Load 0x5A, then reset with load on the same cycle, then resume from 0.
        vec(0, "load5a", 0, 0, 1, 1, 8'h5A, 8'd44, 0, 8'd0);
        vec(0, "rst_ld", 1, 1, 1, 1, 8'd33, 8'h5A, 0, 8'd0);
        vec(0, "resume0", 0, 1, 1, 0, 8'd0, 8'd0, 0, 8'd1);
        vec(0, "resume1", 0, 1, 1, 0, 8'd0, 8'd1, 0, 8'd3);
        vec(0, "hold", 0, 0, 1, 0, 8'd0, 8'd2, 0, 8'd0);
        vec(0, "hold2", 0, 0, 1, 0, 8'd0, 8'd2, 0, 8'd0);

        // Up count M10: at q=9 t_vec=1001.
        for (int i = 0; i < 12; i++) begin
            v = i % 10; nv = (i + 1) % 10;
            vec(1, "up10", 0, 1, 1, 0, 8'd0, 8'(v), (v == 0 && i > 0), 8'(v ^ nv));
        end
        // Down from 0 in M10 wraps to 9.
        vec(1, "rst10", 1, 1, 1, 0, 8'd0, 8'd2, 0, 8'd0);
        vec(1, "dn0", 0, 1, 0, 0, 8'd0, 8'd0, 0, 8'd9);
        vec(1, "dn9", 0, 1, 0, 0, 8'd0, 8'd9, 1, 8'd1);
        vec(1, "dn8", 0, 1, 0, 0, 8'd0, 8'd8, 0, 8'd15);
        vec(1, "dn7", 0, 1, 0, 0, 8'd0, 8'd7, 0, 8'd1);
        vec(1, "dn6", 0, 0, 0, 0, 8'd0, 8'd6, 0, 8'd0);

        // M100: load 200 with en clamps to 99; next up wraps.
        vec(2, "ldclamp", 0, 1, 1, 1, 8'd200, 8'd0, 0, 8'd0);
        vec(2, "up99", 0, 1, 1, 0, 8'd0, 8'd99, 0, 8'd99);
        vec(2, "wrap100", 0, 0, 1, 0, 8'd0, 8'd0, 1, 8'd0);
        vec(2, "ld57", 0, 0, 1, 1, 8'd57, 8'd0, 0, 8'd0);
        vec(2, "ld100", 0, 0, 1, 1, 8'd100, 8'd57, 0, 8'd0);
        vec(2, "clamp99", 0, 0, 1, 0, 8'd0, 8'd99, 0, 8'd0);
        vec(2, "dn99", 0, 1, 0, 0, 8'd0, 8'd99, 0, 8'd1);
        vec(2, "dn98", 0, 0, 0, 0, 8'd0, 8'd98, 0, 8'd0);
`endif

        // M16 up to 15, then 3 more enabled cycles at the limit, then count down.
        for (int i = 0; i < 19; i++) begin
`ifdef T_FF_COUNTER_SATURATE_EN
            v = (i < 15) ? i : 15; nv = (i < 15) ? i + 1 : 15;
            vec(3, "sat16", 0, 1, 1, 0, 8'd0, 8'(v), (i >= 16), 8'(v ^ nv));
`else
            v = i % 16; nv = (i + 1) % 16;
            vec(3, "up16", 0, 1, 1, 0, 8'd0, 8'(v), (i == 16), 8'(v ^ nv));
`endif
        end
`ifdef T_FF_COUNTER_SATURATE_EN
        vec(3, "satdn", 0, 1, 0, 0, 8'd0, 8'd15, 1, 8'd1);
        vec(3, "sat14", 0, 0, 0, 0, 8'd0, 8'd14, 0, 8'd0);
`else
        vec(3, "dn16", 0, 1, 0, 0, 8'd0, 8'd3, 0, 8'd1);
        vec(3, "dn16b", 0, 0, 0, 0, 8'd0, 8'd2, 0, 8'd0);
`endif

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
        @(posedge clk);
        if (sb.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
